// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SUB_WIDTH_DEF = 4;

  // Bit-counter width; a single bit still covers the two-bit minimum operand.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = ai - bi - br, bo = borrow out of this bit.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = ai ^ bi ^ br;
  assign bo = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock behind a start/busy/done handshake.
// Define SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;

`ifdef SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_fs (
    .ai (a_sh[0]),
    .bi (b_sh[0]),
    .br (br),
    .d  (d),
    .bo (bo)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SIGNED_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= ST_RUN;
`ifdef SIGNED_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          // Result fills from the MSB side so bit 0 lands at the bottom after WIDTH shifts.
          res  <= {d, res[WIDTH-1:1]};
          br   <= bo;
          if (cnt == LAST) begin
            cnt        <= '0;
            diff       <= {d, res[WIDTH-1:1]};
            borrow_out <= bo;
            state      <= ST_DONE;
`ifdef SIGNED_OVF_EN
            ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
